// File: rtl/mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_arb_pkg
// Shared types and constants for the shared-multiplier arbiter.
//   arb_state_e       : arbiter FSM states (IDLE, BUSY, RESP)
//   SM_UU..SM_SS      : multiplier signed-mode encodings
//                       (bit 0 = first operand signed, bit 1 = second signed)
//   OP_W              : multiplier operand / result width
// -----------------------------------------------------------------------------
package mul_arb_pkg;

  localparam int unsigned OP_W = 32;

  localparam logic [1:0] SM_UU = 2'b00;
  localparam logic [1:0] SM_SU = 2'b01;
  localparam logic [1:0] SM_US = 2'b10;
  localparam logic [1:0] SM_SS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mul_rr_pick.sv
// -----------------------------------------------------------------------------
// mul_rr_pick
// Combinational round-robin picker. Searches the valid vector starting one
// position after the pointer, wrapping, and returns the first hit.
//   i_valid : request valid vector
//   i_ptr   : index of the most recently served requester
//   o_grant : one-hot grant (zero when nothing is valid)
//   o_idx   : index of the granted requester (0 when nothing is valid)
//   o_any   : at least one request is valid
// -----------------------------------------------------------------------------
module mul_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int               w_cand;
  logic [IDX_W-1:0] w_cand_idx;

  always_comb begin
    // NOTE: every variable written in this block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    o_grant    = '0;
    o_idx      = '0;
    o_any      = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      w_cand_idx = IDX_W'(w_cand);
      if (!o_any && i_valid[w_cand_idx]) begin
        o_grant[w_cand_idx] = 1'b1;
        o_idx               = w_cand_idx;
        o_any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
// Shares one multi-cycle 32x32 multiplier between NUM_REQ requesters. A request
// is granted round-robin in IDLE, its operands are registered and held on the
// multiplier inputs during BUSY, and the result is captured on the multiplier's
// last cycle and offered to the owner in RESP until it is accepted.
//
// Optional build macro: MUL_ARB_FAST_PATH_EN -- requests for the low result
// with both operands fitting in 16 unsigned bits use the multiplier's
// single-cycle mode.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   stall_i                global stall; freezes BUSY, forwarded as mul_stall_o
//   req_valid_i/ready_o    per-requester request handshake (ready one-hot)
//   req_a_i, req_b_i       packed 32-bit operands per requester
//   req_signed_mode_i      packed 2-bit signed mode per requester
//   req_low_i              1 = low result word, 0 = high result word
//   rsp_valid_o/ready_i    per-requester response handshake (valid one-hot)
//   rsp_result_o           registered result shared by all requesters
//   mul_*_o                multiplier control and operands
//   mul_hold_i             multiplier busy, low on its last cycle
//   mul_result_i           multiplier result
// -----------------------------------------------------------------------------
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0] req_a_i,
  input  logic [NUM_REQ*OP_W-1:0] req_b_i,
  input  logic [NUM_REQ*2-1:0]    req_signed_mode_i,
  input  logic [NUM_REQ-1:0]      req_low_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [OP_W-1:0]         rsp_result_o,
  output logic                    mul_stall_o,
  output logic                    mul_enable_o,
  output logic [OP_W-1:0]         mul_first_operand_o,
  output logic [OP_W-1:0]         mul_second_operand_o,
  output logic [1:0]              mul_signed_mode_o,
  output logic                    mul_low_o,
  output logic                    mul_single_cycle_o,
  input  logic                    mul_hold_i,
  input  logic [OP_W-1:0]         mul_result_i
);

  arb_state_e          r_state;
  arb_state_e          w_next_state;
  logic [REQ_ID_W-1:0] r_ptr;
  logic [REQ_ID_W-1:0] r_owner;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [1:0]          r_mode;
  logic                r_low;
  logic                r_issue;
  logic [OP_W-1:0]     r_result;

  logic [NUM_REQ-1:0]  w_grant;
  logic [REQ_ID_W-1:0] w_idx;
  logic                w_any;
  logic                w_accept;
  logic                w_capture;
  logic                w_rsp_done;

  logic [OP_W-1:0]     w_a_arr    [NUM_REQ];
  logic [OP_W-1:0]     w_b_arr    [NUM_REQ];
  logic [1:0]          w_mode_arr [NUM_REQ];
  logic [OP_W-1:0]     w_a_sel;
  logic [OP_W-1:0]     w_b_sel;
  logic [1:0]          w_mode_sel;
  logic                w_low_sel;

  mul_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (REQ_ID_W)
  ) u_pick (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi]    = req_a_i[gi*OP_W +: OP_W];
    assign w_b_arr[gi]    = req_b_i[gi*OP_W +: OP_W];
    assign w_mode_arr[gi] = req_signed_mode_i[gi*2 +: 2];
  end

  assign w_a_sel    = w_a_arr[w_idx];
  assign w_b_sel    = w_b_arr[w_idx];
  assign w_mode_sel = w_mode_arr[w_idx];
  assign w_low_sel  = req_low_i[w_idx];

  assign w_accept   = (r_state == IDLE) && !stall_i && w_any;
  // The multiplier is still idle in the issue cycle, so its hold is ignored there.
  assign w_capture  = (r_state == BUSY) && !stall_i && !r_issue && !mul_hold_i;
  // The response handshake completes regardless of stall_i.
  assign w_rsp_done = (r_state == RESP) && rsp_ready_i[r_owner];

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_next_state = BUSY;
      BUSY:    if (w_capture)  w_next_state = RESP;
      RESP:    if (w_rsp_done) w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    mul_enable_o = 1'b0;
    unique case (r_state)
      IDLE:    if (w_accept) req_ready_o = w_grant;
      BUSY:    mul_enable_o = 1'b1;
      RESP:    rsp_valid_o[r_owner] = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: these are individual flops, not a RAM array, so all of them are
    // reset; the multiplier inputs and result read as zero after reset.
    if (!reset_n) begin
      r_ptr    <= REQ_ID_W'(NUM_REQ - 1);
      r_owner  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= SM_UU;
      r_low    <= 1'b0;
      r_issue  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_ptr   <= w_idx;
        r_owner <= w_idx;
        r_a     <= w_a_sel;
        r_b     <= w_b_sel;
        r_mode  <= w_mode_sel;
        r_low   <= w_low_sel;
        r_issue <= 1'b1;
      end else if ((r_state == BUSY) && !stall_i) begin
        r_issue <= 1'b0;
      end
      if (w_capture) begin
        r_result <= mul_result_i;
      end
    end
  end

`ifdef MUL_ARB_FAST_PATH_EN
  logic w_single;
  logic r_single;

  // Both products fit in 32 bits, so the low word is exact in one cycle.
  assign w_single = w_low_sel && (w_mode_sel == SM_UU) &&
                    (w_a_sel[OP_W-1:16] == '0) && (w_b_sel[OP_W-1:16] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_single <= 1'b0;
    end else if (w_accept) begin
      r_single <= w_single;
    end
  end

  assign mul_single_cycle_o = (r_state == BUSY) && r_single;
`else
  assign mul_single_cycle_o = 1'b0;
`endif

  assign mul_stall_o          = stall_i;
  assign mul_first_operand_o  = r_a;
  assign mul_second_operand_o = r_b;
  assign mul_signed_mode_o    = r_mode;
  assign mul_low_o            = r_low;
  assign rsp_result_o         = r_result;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
// Self-checking bench for mul_share_arbiter. A behavioural multiplier answers
// the arbiter (1 cycle single, 3 cycles low, 4 cycles high, frozen by stall).
// Expected grant order, result and latency come from a reference model built
// from the arbitration rules and plain wide arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int REQ_ID_W = $clog2(NUM_REQ);

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    stall_i = 1'b0;
  logic [NUM_REQ-1:0]      req_valid_i = '0;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [NUM_REQ*32-1:0]   req_a_i = '0;
  logic [NUM_REQ*32-1:0]   req_b_i = '0;
  logic [NUM_REQ*2-1:0]    req_signed_mode_i = '0;
  logic [NUM_REQ-1:0]      req_low_i = '0;
  logic [NUM_REQ-1:0]      rsp_valid_o;
  logic [NUM_REQ-1:0]      rsp_ready_i = '0;
  logic [31:0]             rsp_result_o;
  logic                    mul_stall_o;
  logic                    mul_enable_o;
  logic [31:0]             mul_first_operand_o;
  logic [31:0]             mul_second_operand_o;
  logic [1:0]              mul_signed_mode_o;
  logic                    mul_low_o;
  logic                    mul_single_cycle_o;
  logic                    mul_hold_i;
  logic [31:0]             mul_result_i;

  int n_checks = 0;
  int n_errors = 0;
  int ref_ptr  = NUM_REQ - 1;

  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];
  logic [1:0]  op_m [NUM_REQ];
  logic        op_l [NUM_REQ];

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .stall_i              (stall_i),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_a_i              (req_a_i),
    .req_b_i              (req_b_i),
    .req_signed_mode_i    (req_signed_mode_i),
    .req_low_i            (req_low_i),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_ready_i          (rsp_ready_i),
    .rsp_result_o         (rsp_result_o),
    .mul_stall_o          (mul_stall_o),
    .mul_enable_o         (mul_enable_o),
    .mul_first_operand_o  (mul_first_operand_o),
    .mul_second_operand_o (mul_second_operand_o),
    .mul_signed_mode_o    (mul_signed_mode_o),
    .mul_low_o            (mul_low_o),
    .mul_single_cycle_o   (mul_single_cycle_o),
    .mul_hold_i           (mul_hold_i),
    .mul_result_i         (mul_result_i)
  );

  // ------------------------------------------------------------ ref model
  // Full 64-bit product; mode bit 0 = first operand signed, bit 1 = second.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m, input logic low);
    logic signed [65:0] ea, eb, p;
    ea = m[0] ? {{34{a[31]}}, a} : {34'd0, a};
    eb = m[1] ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ea * eb;
    return low ? p[31:0] : p[63:32];
  endfunction

  function automatic logic ref_single(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] m, input logic low);
`ifdef MUL_ARB_FAST_PATH_EN
    return low && (m == 2'b00) && (a < 32'h1_0000) && (b < 32'h1_0000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_lat(input logic single, input logic low);
    if (single) return 3;
    return low ? 5 : 6;
  endfunction

  function automatic int ref_pick(input logic [NUM_REQ-1:0] pend, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (ptr + k) % NUM_REQ;
      if (pend[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] one;
    one = 1;
    return one << g;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 32'h0000_FFFF));
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ------------------------------------------------------------ multiplier
  int          m_rem;
  logic [31:0] m_res;

  assign mul_hold_i   = (m_rem > 1);
  assign mul_result_i = m_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem <= 0;
      m_res <= '0;
    end else if (!mul_stall_o) begin
      if (m_rem == 0 && mul_enable_o) begin
        m_rem <= mul_single_cycle_o ? 1 : (mul_low_o ? 3 : 4);
        m_res <= ref_mul(mul_first_operand_o, mul_second_operand_o,
                         mul_signed_mode_o, mul_low_o);
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end
    end
  end

  // ------------------------------------------------------------ checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  req_ready_o, 0);
    check({tag, "_rspv"},   rsp_valid_o, 0);
    check({tag, "_result"}, rsp_result_o, 0);
    check({tag, "_en"},     mul_enable_o, 0);
    check({tag, "_a"},      mul_first_operand_o, 0);
    check({tag, "_b"},      mul_second_operand_o, 0);
    check({tag, "_mode"},   mul_signed_mode_o, 0);
    check({tag, "_low"},    mul_low_o, 0);
    check({tag, "_single"}, mul_single_cycle_o, 0);
    check({tag, "_stall"},  mul_stall_o, stall_i);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input logic l);
    op_a[i] = a; op_b[i] = b; op_m[i] = m; op_l[i] = l;
  endtask

  // Raise valid on every requester in mask, then serve them in predicted
  // round-robin order. The first operation may be stalled for st_len cycles
  // starting st_at cycles after its accept.
  task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int hold_cyc,
                           input int st_at, input int st_len);
    logic [NUM_REQ-1:0] pend;
    int                 g, lat, exp_lat, nwait;
    logic [31:0]        exp_res;
    logic               exp_single;
    bit                 first, at_neg;
    pend = mask; first = 1'b1; at_neg = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_i[i*32 +: 32]         = op_a[i];
      req_b_i[i*32 +: 32]         = op_b[i];
      req_signed_mode_i[i*2 +: 2] = op_m[i];
      req_low_i[i]                = op_l[i];
    end
    req_valid_i = mask;
    while (pend != '0) begin
      g          = ref_pick(pend, ref_ptr);
      exp_res    = ref_mul(op_a[g], op_b[g], op_m[g], op_l[g]);
      exp_single = ref_single(op_a[g], op_b[g], op_m[g], op_l[g]);
      exp_lat    = ref_lat(exp_single, op_l[g]) + (first ? st_len : 0);
      if (!at_neg) @(negedge clk);
      at_neg = 1'b0;
      nwait  = 0;
      while (req_ready_o == '0 && nwait < 8) begin
        @(negedge clk);
        nwait++;
      end
      check("grant", req_ready_o, onehot(g));
      check("grant_wait", nwait, 0);
      @(posedge clk); #1;
      req_valid_i[g] = 1'b0;
      pend[g]        = 1'b0;
      ref_ptr        = g;
      lat            = 1;
      stall_i        = first && (lat >= st_at) && (lat < st_at + st_len);
      forever begin
        @(negedge clk);
        check("mul_stall", mul_stall_o, stall_i);
        if (rsp_valid_o != '0) break;
        check("busy_en",     mul_enable_o, 1);
        check("busy_a",      mul_first_operand_o, op_a[g]);
        check("busy_b",      mul_second_operand_o, op_b[g]);
        check("busy_mode",   mul_signed_mode_o, op_m[g]);
        check("busy_low",    mul_low_o, op_l[g]);
        check("busy_single", mul_single_cycle_o, exp_single);
        if (lat >= 40) begin
          check("rsp_timeout", rsp_valid_o, onehot(g));
          break;
        end
        @(posedge clk); #1;
        lat++;
        stall_i = first && (lat >= st_at) && (lat < st_at + st_len);
      end
      stall_i = 1'b0;
      check("rsp_lat",      lat, exp_lat);
      check("rsp_valid",    rsp_valid_o, onehot(g));
      check("rsp_result",   rsp_result_o, exp_res);
      check("rsp_en_off",   mul_enable_o, 0);
      check("rsp_no_grant", req_ready_o, 0);
      for (int h = 0; h < hold_cyc; h++) begin
        @(posedge clk); #1;
        rsp_ready_i = ~onehot(g);
        @(negedge clk);
        check("hold_valid",  rsp_valid_o, onehot(g));
        check("hold_result", rsp_result_o, exp_res);
      end
      @(posedge clk); #1;
      rsp_ready_i = onehot(g);
      stall_i     = (st_len > 0);
      @(posedge clk); #1;
      rsp_ready_i = '0;
      stall_i     = 1'b0;
      @(negedge clk);
      check("rsp_done", rsp_valid_o, 0);
      at_neg = 1'b1;
      first  = 1'b0;
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [NUM_REQ-1:0] rmask;

    for (int i = 0; i < NUM_REQ; i++) set_op(i, 0, 0, 2'b00, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    stall_i = 1'b1; #1;
    check("reset_stall_fwd", mul_stall_o, 1);
    stall_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ref_ptr = NUM_REQ - 1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Contention from reset: requester 0 first, then 1
    set_op(0, 32'd3, 32'd5, 2'b00, 1'b1);
    set_op(1, 32'd11, 32'd13, 2'b00, 1'b0);
    run_batch(2'b11, 0, 0, 0);

    // Single request 7*6 = 42, held two cycles before acceptance
    set_op(0, 32'd7, 32'd6, 2'b00, 1'b1);
    run_batch(2'b01, 2, 0, 0);

    // Simultaneous pair after requester 0 was served: 1 before 0
    set_op(0, 32'h0001_0000, 32'h0000_0003, 2'b11, 1'b1);
    set_op(1, 32'hFFFF_FFFE, 32'h0000_0005, 2'b01, 1'b0);
    run_batch(2'b11, 1, 0, 0);

    // High result, signed and unsigned
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b0);
    run_batch(2'b01, 0, 0, 0);
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0);
    run_batch(2'b01, 0, 0, 0);

    // Three-cycle stall in the middle of BUSY
    set_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 1'b1);
    run_batch(2'b10, 1, 2, 3);

    // Fast-path candidate
    set_op(0, 32'h0000_1234, 32'h0000_0010, 2'b00, 1'b1);
    run_batch(2'b01, 0, 0, 0);

    // Valid raised under stall then dropped: no grant, no state change
    @(posedge clk); #1;
    stall_i     = 1'b1;
    req_valid_i = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_no_grant", req_ready_o, 0);
    end
    @(posedge clk); #1;
    req_valid_i = '0;
    stall_i     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drop_no_grant", req_ready_o, 0);
      check("drop_idle_en",  mul_enable_o, 0);
    end

    // Reset during BUSY
    set_op(0, 32'hDEAD_BEEF, 32'h0000_0123, 2'b00, 1'b0);
    @(posedge clk); #1;
    req_a_i[31:0]          = op_a[0];
    req_b_i[31:0]          = op_b[0];
    req_signed_mode_i[1:0] = op_m[0];
    req_low_i[0]           = op_l[0];
    req_valid_i            = 2'b01;
    @(negedge clk);
    check("rstmid_grant", req_ready_o, 2'b01);
    @(posedge clk); #1;
    req_valid_i = '0;
    @(negedge clk);
    check("rstmid_busy", mul_enable_o, 1);
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check_reset_outputs("rstmid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    ref_ptr = NUM_REQ - 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rstmid_no_rsp", rsp_valid_o, 0);
    end
    set_op(0, 32'd9, 32'd9, 2'b00, 1'b1);
    set_op(1, 32'd2, 32'd8, 2'b10, 1'b0);
    run_batch(2'b11, 0, 0, 0);

    // Randomized batches
    for (int it = 0; it < 20; it++) begin
      rmask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        set_op(i, rand_operand(), rand_operand(), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      end
      run_batch(rmask, $urandom_range(0, 2), $urandom_range(1, 2),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one multi-cycle 32x32 partial-product multiplier between NUM_REQ requesters, e.g. an integer pipe and a coprocessor port.
- Accepts requests on valid/ready handshakes and picks one with round-robin arbitration.
- Registers the winning operands and drives the multiplier's enable/mode inputs for the whole operation.
- Captures the result on the multiplier's last cycle and returns it to the owning requester on a valid/ready response channel.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- REQ_ID_W, $clog2(NUM_REQ), width of the internal owner index.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  global pipeline stall; forwarded to the multiplier and freezes the arbiter.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*32  first operand per requester.
- req_b_i  in  NUM_REQ*32  second operand per requester.
- req_signed_mode_i  in  NUM_REQ*2  signed mode per requester (00 uu, 01 su, 10 us, 11 ss).
- req_low_i  in  NUM_REQ  1 = low 32 result bits, 0 = high 32 result bits.
- rsp_valid_o  out  NUM_REQ  response valid; one-hot or zero.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_result_o  out  32  registered result, shared by all requesters.
- mul_stall_o  out  1  equals stall_i.
- mul_enable_o  out  1  multiplier enable.
- mul_first_operand_o  out  32  multiplier first operand.
- mul_second_operand_o  out  32  multiplier second operand.
- mul_signed_mode_o  out  2  multiplier signed mode.
- mul_low_o  out  1  multiplier low/high select.
- mul_single_cycle_o  out  1  multiplier single-cycle request.
- mul_hold_i  in  1  multiplier busy; low on its last cycle.
- mul_result_i  in  32  multiplier result, valid when mul_hold_i=0 after issue.

Behaviour:
- Reset: state IDLE, rr pointer = NUM_REQ-1 (so requester 0 wins first), all operand/mode/result registers 0. All outputs 0 except mul_stall_o, which follows stall_i.
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If !stall_i and any req_valid_i is set, pick the first valid requester searching from pointer+1, wrapping.
  - Assert req_ready_o[g] combinationally in that cycle.
  - Latch a, b, mode, low and owner g. Set pointer = g. Go to BUSY.
  - If stall_i, grant nothing and set req_ready_o = 0.
- BUSY:
  - mul_enable_o = 1. All mul_* operand and mode outputs come from the latched registers and stay stable.
  - The first BUSY cycle is the issue cycle (multiplier still idle); mul_hold_i is ignored there.
  - In any later BUSY cycle with mul_hold_i=0 and !stall_i: capture mul_result_i into rsp_result_o and go to RESP.
  - stall_i freezes the state and all registers.
- RESP:
  - mul_enable_o = 0; rsp_valid_o[owner] = 1.
  - rsp_result_o stays stable until rsp_ready_i[owner] is seen; then go to IDLE.
  - There is no grant in RESP, so one bubble is inserted before the next grant.
  - stall_i does not block the response handshake.
- Latency from accept cycle t to rsp_valid_o:
  - single-cycle: t+3.
  - low result, 4 partial products minus AHBH: t+5.
  - high result: t+6.
- Simultaneous valids: round-robin. Each requester waits at most NUM_REQ-1 operations.
- Requester valid dropped before grant: no grant, no state change.
- Reset mid-operation returns everything to reset values. Any in-flight result is discarded and no response is issued.
- mul_single_cycle_o = 0 unless the optional feature is enabled.

Optional Feature:
- Macro: MUL_ARB_FAST_PATH_EN.
- When defined:
  - At grant, compute single = low && both upper 16 operand bits are zero && mode==00.
  - Latch single and drive mul_single_cycle_o from it for the whole BUSY period.
- When undefined: mul_single_cycle_o is tied to 0 and every low-result operation takes t+5.

Decomposition:
- Package mul_arb_pkg:
  - state enum (IDLE, BUSY, RESP).
  - signed-mode localparams SM_UU, SM_SU, SM_US, SM_SS.
  - operand width constant 32.
- One natural sub-module, mul_rr_pick: combinational round-robin picker (valid vector + pointer -> one-hot grant + index). Reused for future shared units.

Test Plan:
- Single request: req0 a=7, b=6, low=1, mode 00 (fast path off) -> ready0 at t, rsp_valid_o[0] at t+5, result 42, held until rsp_ready_i[0].
- Contention: req0 and req1 valid together from reset -> req0 granted first, req1 next; a second simultaneous pair grants req1 before req0.
- High result: a=0xFFFFFFFF, b=0xFFFFFFFF, mode 11, low=0 -> result 0x00000000 at t+6. Mode 00 gives 0xFFFFFFFE.
- Stall: assert stall_i for 3 cycles mid-BUSY -> operands and state frozen, response delayed by exactly 3 cycles, result unchanged.
- Fast path (MUL_ARB_FAST_PATH_EN): a=0x1234, b=0x10, low=1 -> mul_single_cycle_o=1, result 0x12340 at t+3.
- Reset mid-operation: drop reset_n in BUSY -> all outputs 0 immediately, no response afterwards, next request served normally from requester 0.
